// File: rtl/phase_sequencer.sv
// phase_sequencer: microstep sequencer for the microcoded core.
// Drives phase/fetch to the decoder, pulses the IR load, owns the interrupt
// enable flag and arbitrates fetch/execute, exception/IRQ entry, WAIT and HALT.
// Exception and IRQ entry are done by injecting a synthetic INT instruction,
// so the decoder's existing INT microcode performs the vectoring.
module phase_sequencer #(
  parameter logic [8:0] EXC_VEC     = 9'd0,
  parameter logic [8:0] TIMEOUT_VEC = 9'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ucode_end,
  input  logic        halt_req,
  input  logic        wait_req,
  input  logic        ei,
  input  logic        di,
  input  logic        rti,
  input  logic        exc_req,
  input  logic        irq,
  input  logic [8:0]  irq_vec,
  output logic [2:0]  phase,
  output logic        fetch,
  output logic        exc_triggered,
  output logic        ir_load,
  output logic        ir_inject,
  output logic [15:0] inject_insn,
  output logic        ie,
  output logic        halted,
  output logic        waiting
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_EXC,
    ST_WAIT,
    ST_HALT
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [8:0] vec9;
  logic [8:0] next_vec;
  logic       exc_pend;
  logic       exc_loaded;   // EXC has already issued its injected IR load
  logic       next_ie;
  logic       take_exc;     // enter (or re-enter) EXC this cycle
  logic       exc_cause;    // the entry is caused by a synchronous exception
  logic       irq_ok;
  logic       exc_any;
  logic       phase_max;
  logic       exc_load_cycle;
  logic       exc_set;
  logic       transition;

  assign irq_ok         = irq & ie;
  assign exc_any        = exc_req | exc_pend;
  assign phase_max      = (phase == 3'd7);
  assign exc_load_cycle = (state == ST_EXC) && !exc_loaded;

  // Next-state arbitration, IE update and vector selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    next_state = state;
    next_vec   = vec9;
    next_ie    = ie;
    take_exc   = 1'b0;
    exc_cause  = 1'b0;
    unique case (state)
      ST_FETCH: begin
        if (ucode_end) begin
          next_state = ST_EXEC;
        end else if (phase_max) begin
          take_exc = 1'b1;
          next_vec = TIMEOUT_VEC;
        end
      end
      ST_EXEC: begin
        if (ucode_end) begin
          if (ei || rti) next_ie = 1'b1;
          else if (di)   next_ie = 1'b0;
          if (exc_any) begin
            take_exc  = 1'b1;
            exc_cause = 1'b1;
            next_vec  = EXC_VEC;
          end else if (halt_req) begin
            next_state = ST_HALT;
          end else if (wait_req) begin
            next_state = ST_WAIT;
          end else if (irq_ok) begin
            take_exc = 1'b1;
            next_vec = irq_vec;
          end else begin
            next_state = ST_FETCH;
          end
        end else if (phase_max) begin
          take_exc = 1'b1;
          next_vec = TIMEOUT_VEC;
        end
      end
      ST_EXC: begin
        // The load cycle belongs to the injection; the INT microprogram starts after it.
        if (!exc_load_cycle) begin
          if (ucode_end) begin
            next_state = ST_FETCH;
          end else if (phase_max) begin
            take_exc = 1'b1;
            next_vec = TIMEOUT_VEC;
          end
        end
      end
      ST_WAIT: begin
        if (exc_any) begin
          take_exc  = 1'b1;
          exc_cause = 1'b1;
          next_vec  = EXC_VEC;
        end else if (irq_ok) begin
          take_exc = 1'b1;
          next_vec = irq_vec;
        end else if (irq) begin
          next_state = ST_FETCH;
        end
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_FETCH;
      end
    endcase
    if (take_exc) begin
      next_state = ST_EXC;
      next_ie    = 1'b0;
    end
  end

  // A re-entry into EXC counts as a transition even though the state code is unchanged.
  assign transition = take_exc || (next_state != state);

  // A new request always lands in exc_pend, except the one that is itself
  // causing this entry (it is consumed by the entry, not re-queued).
  assign exc_set = exc_req && (state != ST_HALT) && !(!stall && take_exc && exc_cause);

  // Sequencer state; stall freezes everything except exception latching.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state      <= ST_FETCH;
      phase      <= 3'd0;
      ie         <= 1'b0;
      exc_pend   <= 1'b0;
      exc_loaded <= 1'b0;
      vec9       <= 9'd0;
    end else begin
      exc_pend <= exc_set || (exc_pend && !(!stall && take_exc));
      if (!stall) begin
        state      <= next_state;
        ie         <= next_ie;
        exc_loaded <= (next_state == ST_EXC) && !take_exc;
        if (take_exc) vec9 <= next_vec;
        if (transition) begin
          phase <= 3'd0;
        end else if (!ucode_end && !exc_load_cycle &&
                     (state == ST_FETCH || state == ST_EXEC || state == ST_EXC)) begin
          phase <= phase + 3'd1;
        end
      end
    end
  end

  // Combinational output decode; the IR load is suppressed during stall and reset.
  always_comb begin
    fetch         = (state == ST_FETCH);
    exc_triggered = (state == ST_EXC);
    halted        = (state == ST_HALT);
    waiting       = (state == ST_WAIT);
    ir_load       = rst_n && !stall &&
                    (((state == ST_FETCH) && ucode_end) || exc_load_cycle);
    ir_inject     = ir_load && exc_load_cycle;
    inject_insn   = {3'b100, 4'b0000, vec9};
  end

endmodule
